// File: rtl/ifu.sv
// Multicycle instruction fetch unit: one memory read per instruction, result held for decode,
// then waits for dnpc. Optional misaligned-PC trap when IFU_ALIGN_CHECK_EN is defined.
module ifu #(
  parameter int                   ISA_WIDTH = 32,
  parameter logic [ISA_WIDTH-1:0] RESET_PC  = 32'h80000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 mem_req,
  output logic [ISA_WIDTH-1:0] mem_addr,
  input  logic                 mem_ack,
  input  logic [ISA_WIDTH-1:0] mem_rdata,
  input  logic                 mem_err,
  output logic [ISA_WIDTH-1:0] inst,
  output logic [ISA_WIDTH-1:0] inst_pc,
  output logic                 inst_valid,
  input  logic                 inst_ready,
  input  logic [ISA_WIDTH-1:0] dnpc,
  input  logic                 dnpc_valid,
  output logic                 fetch_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_VALID,
    S_WAIT_NPC,
    S_ERR
  } state_e;

  state_e                 state_q,     state_d;
  logic [ISA_WIDTH-1:0]   pc_q,        pc_d;
  logic [ISA_WIDTH-1:0]   inst_q,      inst_d;
  logic [ISA_WIDTH-1:0]   inst_pc_q,   inst_pc_d;
  logic                   fetch_err_q, fetch_err_d;

  // NOTE: every always_comb output gets its hold value first, so no path leaves a latch.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    inst_pc_d   = inst_pc_q;
    fetch_err_d = fetch_err_q;

    unique case (state_q)
      S_IDLE: begin
`ifdef IFU_ALIGN_CHECK_EN
        if (RESET_PC[1:0] != 2'b00) begin
          fetch_err_d = 1'b1;
          state_d     = S_ERR;
        end else begin
          state_d = S_REQ;
        end
`else
        state_d = S_REQ;
`endif
      end

      S_REQ: begin
        if (mem_ack) begin
          if (mem_err) begin
            fetch_err_d = 1'b1;
            state_d     = S_ERR;
          end else begin
            inst_d    = mem_rdata;
            inst_pc_d = pc_q;
            state_d   = S_VALID;
          end
        end
      end

      S_VALID: begin
        if (inst_ready) begin
          state_d = S_WAIT_NPC;
        end
      end

      S_WAIT_NPC: begin
        if (dnpc_valid) begin
          pc_d = dnpc;
`ifdef IFU_ALIGN_CHECK_EN
          if (dnpc[1:0] != 2'b00) begin
            fetch_err_d = 1'b1;
            state_d     = S_ERR;
          end else begin
            state_d = S_REQ;
          end
`else
          state_d = S_REQ;
`endif
        end
      end

      S_ERR: begin
        state_d = S_ERR;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      inst_q      <= '0;
      inst_pc_q   <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      inst_pc_q   <= inst_pc_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  // Decoded straight from the state flop so reset drops mem_req without waiting for an edge.
  assign mem_req    = (state_q == S_REQ);
  assign inst_valid = (state_q == S_VALID);
  assign mem_addr   = pc_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign fetch_err  = fetch_err_q;

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: directed scenarios with literal expectations, then randomized
// traffic compared every cycle against a transaction-level model of the fetch unit.
module tb_ifu;

  localparam logic [31:0] RESET_PC = 32'h80000000;
`ifdef IFU_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_err;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] dnpc;
  logic        dnpc_valid;
  logic        fetch_err;

  int checks = 0;
  int errors = 0;

  ifu #(.ISA_WIDTH(32), .RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .mem_err    (mem_err),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .dnpc       (dnpc),
    .dnpc_valid (dnpc_valid),
    .fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: which phase of the fetch life cycle we are in, plus the data.
  logic        m_started, m_fetching, m_holding, m_waiting, m_faulted;
  logic [31:0] m_pc, m_inst, m_inst_pc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_started  <= 1'b0;
      m_fetching <= 1'b0;
      m_holding  <= 1'b0;
      m_waiting  <= 1'b0;
      m_faulted  <= 1'b0;
      m_pc       <= RESET_PC;
      m_inst     <= 32'h0;
      m_inst_pc  <= 32'h0;
    end else if (m_faulted) begin
      m_faulted <= 1'b1;
    end else if (!m_started) begin
      m_started <= 1'b1;
      if (ALIGN && (RESET_PC % 4) != 0) m_faulted  <= 1'b1;
      else                              m_fetching <= 1'b1;
    end else if (m_fetching) begin
      if (mem_ack) begin
        m_fetching <= 1'b0;
        if (mem_err) begin
          m_faulted <= 1'b1;
        end else begin
          m_holding <= 1'b1;
          m_inst    <= mem_rdata;
          m_inst_pc <= m_pc;
        end
      end
    end else if (m_holding) begin
      if (inst_ready) begin
        m_holding <= 1'b0;
        m_waiting <= 1'b1;
      end
    end else if (m_waiting && dnpc_valid) begin
      m_waiting <= 1'b0;
      m_pc      <= dnpc;
      if (ALIGN && (dnpc % 4) != 0) m_faulted  <= 1'b1;
      else                          m_fetching <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_mem_req",    mem_req,    1'b0);
      check("rst_inst_valid", inst_valid, 1'b0);
      check("rst_fetch_err",  fetch_err,  1'b0);
      check("rst_mem_addr",   mem_addr,   RESET_PC);
      check("rst_inst",       inst,       32'h0);
      check("rst_inst_pc",    inst_pc,    32'h0);
    end else begin
      check("mem_req",    mem_req,    m_fetching);
      check("inst_valid", inst_valid, m_holding);
      check("fetch_err",  fetch_err,  m_faulted);
      check("mem_addr",   mem_addr,   m_pc);
      check("inst",       inst,       m_inst);
      check("inst_pc",    inst_pc,    m_inst_pc);
    end
  end

  task automatic adv();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    mem_ack    = 1'b0;
    mem_err    = 1'b0;
    mem_rdata  = 32'h0;
    inst_ready = 1'b0;
    dnpc       = 32'h0;
    dnpc_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();

    // T1: reset held 3 cycles, first request one cycle after release
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk); #1;
    check("t1_req_at_release",   mem_req,    1'b0);
    check("t1_valid_at_release", inst_valid, 1'b0);
    check("t1_addr_at_release",  mem_addr,   32'h80000000);
    adv();
    check("t1_first_req",  mem_req,  1'b1);
    check("t1_first_addr", mem_addr, 32'h80000000);

    // T2: zero-wait ack
    mem_ack   = 1'b1;
    mem_rdata = 32'h00000513;
    adv();
    mem_ack    = 1'b0;
    mem_rdata  = 32'hffffffff;
    dnpc       = 32'hdeadbee0;
    dnpc_valid = 1'b1;
    check("t2_valid",   inst_valid, 1'b1);
    check("t2_inst",    inst,       32'h00000513);
    check("t2_inst_pc", inst_pc,    32'h80000000);

    // T3: backpressure, then handshake (dnpc_valid held high throughout is ignored)
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_valid", inst_valid, 1'b1);
      check("t3_hold_inst",  inst,       32'h00000513);
      if (i < 4) adv();
    end
    inst_ready = 1'b1;
    adv();
    inst_ready = 1'b0;
    check("t3_valid_drop", inst_valid, 1'b0);
    check("t3_no_req",     mem_req,    1'b0);

    // T4: dnpc in WAIT_NPC, memory stalls 3 cycles
    dnpc       = 32'h80000004;
    dnpc_valid = 1'b1;
    adv();
    dnpc_valid = 1'b0;
    dnpc       = 32'h11111110;
    check("t4_req",  mem_req,  1'b1);
    check("t4_addr", mem_addr, 32'h80000004);
    for (int i = 0; i < 3; i++) begin
      adv();
      check("t4_stall_req",  mem_req,  1'b1);
      check("t4_stall_addr", mem_addr, 32'h80000004);
    end
    mem_ack   = 1'b1;
    mem_rdata = 32'h00a00593;
    adv();
    mem_ack = 1'b0;
    check("t4_inst",    inst,    32'h00a00593);
    check("t4_inst_pc", inst_pc, 32'h80000004);
    check("t4_req_off", mem_req, 1'b0);

    // T5: bus error is terminal until reset
    inst_ready = 1'b1;
    adv();
    inst_ready = 1'b0;
    dnpc       = 32'h80000008;
    dnpc_valid = 1'b1;
    adv();
    dnpc_valid = 1'b0;
    check("t5_addr", mem_addr, 32'h80000008);
    mem_ack = 1'b1;
    mem_err = 1'b1;
    adv();
    check("t5_err",    fetch_err, 1'b1);
    check("t5_no_req", mem_req,   1'b0);
    for (int i = 0; i < 6; i++) begin
      mem_ack    = 1'($urandom_range(0, 1));
      mem_err    = 1'($urandom_range(0, 1));
      inst_ready = 1'($urandom_range(0, 1));
      dnpc_valid = 1'($urandom_range(0, 1));
      adv();
      check("t5_err_sticky", fetch_err,  1'b1);
      check("t5_req_low",    mem_req,    1'b0);
      check("t5_valid_low",  inst_valid, 1'b0);
    end
    clear_inputs();
    rst_n = 1'b0;
    #1;
    check("t5_err_cleared",  fetch_err, 1'b0);
    check("t5_req_reset",    mem_req,   1'b0);
    adv();
    rst_n = 1'b1;

    // T6: misaligned dnpc
    adv();
    check("t6_pre_req", mem_req, 1'b1);
    mem_ack   = 1'b1;
    mem_rdata = 32'h00000013;
    adv();
    mem_ack    = 1'b0;
    inst_ready = 1'b1;
    adv();
    inst_ready = 1'b0;
    dnpc       = 32'h80000006;
    dnpc_valid = 1'b1;
    adv();
    dnpc_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
`ifdef IFU_ALIGN_CHECK_EN
      check("t6_align_err",    fetch_err, 1'b1);
      check("t6_align_no_req", mem_req,   1'b0);
`else
      check("t6_unaligned_req",  mem_req,  1'b1);
      check("t6_unaligned_addr", mem_addr, 32'h80000006);
`endif
      adv();
    end

    rst_n = 1'b0;
    clear_inputs();
    adv();
    rst_n = 1'b1;

    // Randomized traffic, including inputs outside their state and async reset pulses
    for (int n = 0; n < 4000; n++) begin
      adv();
      mem_ack    = ($urandom_range(0, 2) == 0);
      mem_err    = ($urandom_range(0, 15) == 0);
      mem_rdata  = $urandom;
      inst_ready = ($urandom_range(0, 1) == 0);
      dnpc_valid = ($urandom_range(0, 3) == 0);
      dnpc       = $urandom;
      if ($urandom_range(0, 7) != 0) dnpc[1:0] = 2'b00;
      if (!rst_n) begin
        rst_n = 1'b1;
      end else if ($urandom_range(0, 199) == 0 || (fetch_err && $urandom_range(0, 7) == 0)) begin
        rst_n = 1'b0;
      end
    end

    @(negedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
